// File: rtl/generic_spram_pkg.sv
// generic_spram_pkg
//   Shared types and sizing helpers for the generic single-port RAM controller.
//   - calc_bank_w / calc_row_w / calc_mask_w : derived widths from parameters
//   - state_e      : controller FSM state (INIT clears the array, RUN serves requests)
//   - pipe_entry_t : one stage of the read-latency tracking pipeline
package generic_spram_pkg;

   // Upper bound on bank-id bits carried through the read pipeline.
   localparam int MAX_BANK_W = 8;

   function automatic int calc_bank_w(input int banks);
      return (banks > 1) ? $clog2(banks) : 0;
   endfunction

   // A single-row bank still needs a 1-bit row port.
   function automatic int calc_row_w(input int depth, input int banks);
      return ((depth / banks) > 1) ? $clog2(depth / banks) : 1;
   endfunction

   function automatic int calc_mask_w(input int data_w, input int part_w);
      return data_w / part_w;
   endfunction

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic                  valid;
      logic [MAX_BANK_W-1:0] bank;
   } pipe_entry_t;

endpackage

// File: rtl/generic_spram_bank.sv
// generic_spram_bank
//   One bank of behavioural single-port storage with a RAM_LATENCY deep
//   read-data pipeline. Read data for a read sampled at edge k is on rdata_o
//   after edge k+RAM_LATENCY-1 and stays there for one cycle.
//   Ports:
//     clk_i   : clock
//     ce_i    : bank enable; no access when low
//     we_i    : 1 = write, 0 = read (when ce_i)
//     mask_i  : per-partition write enable
//     row_i   : row address inside the bank
//     wdata_i : write data
//     rdata_o : read data at the end of the latency pipeline
module generic_spram_bank
   import generic_spram_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int PART_W      = 8,
   parameter int ROWS        = 256,
   parameter int ROW_W       = 8,
   parameter int RAM_LATENCY = 1
) (
   input  logic                                    clk_i,
   input  logic                                    ce_i,
   input  logic                                    we_i,
   input  logic [calc_mask_w(DATA_W, PART_W)-1:0]  mask_i,
   input  logic [ROW_W-1:0]                        row_i,
   input  logic [DATA_W-1:0]                       wdata_i,
   output logic [DATA_W-1:0]                       rdata_o
);

   localparam int MASK_W = calc_mask_w(DATA_W, PART_W);

   logic [DATA_W-1:0] mem_q  [ROWS];
   logic [DATA_W-1:0] pipe_q [RAM_LATENCY];

   // Storage and read data are not reset: contents survive reset and the
   // controller tracks validity of pipeline data separately.
   always_ff @(posedge clk_i) begin
      if (ce_i && we_i) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (mask_i[i]) begin
               mem_q[row_i][i*PART_W +: PART_W] <= wdata_i[i*PART_W +: PART_W];
            end
         end
      end
      if (ce_i && !we_i) begin
         pipe_q[0] <= mem_q[row_i];
      end
      for (int s = 1; s < RAM_LATENCY; s++) begin
         pipe_q[s] <= pipe_q[s-1];
      end
   end

   assign rdata_o = pipe_q[RAM_LATENCY-1];

endmodule

// File: rtl/generic_spram_ctrl.sv
// generic_spram_ctrl
//   Single-port RAM controller: BANKS address-interleaved banks, valid/ready
//   request port, in-order read response queue with backpressure, partial
//   writes and an optional post-reset clear of the whole array.
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high; ready never depends on valid, and a valid request holds its
//   payload until it is accepted.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     req_valid / req_ready   : request handshake
//     req_we, req_biten       : write select, per-partition write enable
//     req_addr, req_wdata     : word address, write data
//     resp_valid / resp_ready : read response handshake
//     resp_rdata              : read data, 0 when resp_valid is low
//     init_done               : array usable
//     dbg_state               : current FSM state (debug)
module generic_spram_ctrl
   import generic_spram_pkg::*;
#(
   parameter int                 DATA_W        = 64,
   parameter int                 PART_W        = 8,
   parameter int                 DEPTH         = 512,
   parameter int                 BANKS         = 2,
   parameter int                 RAM_LATENCY   = 1,
   parameter bit                 INIT_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0]  INIT_VALUE    = '0
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic                                   req_we,
   input  logic [calc_mask_w(DATA_W, PART_W)-1:0] req_biten,
   input  logic [$clog2(DEPTH)-1:0]               req_addr,
   input  logic [DATA_W-1:0]                      req_wdata,
   output logic                                   resp_valid,
   input  logic                                   resp_ready,
   output logic [DATA_W-1:0]                      resp_rdata,
   output logic                                   init_done,
   output logic                                   dbg_state
);

   localparam int ADDR_W  = $clog2(DEPTH);
   localparam int BANK_W  = calc_bank_w(BANKS);
   localparam int BANK_IW = (BANK_W > 0) ? BANK_W : 1;
   localparam int ROWS    = DEPTH / BANKS;
   localparam int ROW_W   = calc_row_w(DEPTH, BANKS);
   localparam int MASK_W  = calc_mask_w(DATA_W, PART_W);
   localparam int CAP     = RAM_LATENCY + 1;
   localparam int CNT_W   = $clog2(CAP + 1);
   localparam int QPTR_W  = $clog2(CAP);

   state_e             state_q;
   logic [ROW_W-1:0]   init_row_q;
   logic               init_done_q;

   pipe_entry_t        pipe_q [RAM_LATENCY];
   logic [CNT_W-1:0]   out_cnt_q;

   logic [DATA_W-1:0]  q_mem_q [CAP];
   logic [QPTR_W-1:0]  q_head_q, q_tail_q;
   logic [CNT_W-1:0]   q_occ_q;

   logic               accept, rd_acc;
   logic [BANK_IW-1:0] bank_sel;
   logic [ROW_W-1:0]   row_sel;
   logic [BANKS-1:0]   bank_ce;
   logic               bank_we;
   logic [MASK_W-1:0]  bank_mask;
   logic [ROW_W-1:0]   bank_row;
   logic [DATA_W-1:0]  bank_wdata;
   logic [DATA_W-1:0]  bank_rdata [BANKS];

   logic               arr_valid;
   logic [DATA_W-1:0]  arr_data;
   logic               q_empty, push, pop;
   logic [DATA_W-1:0]  resp_raw;

   // Credit rule: reads in flight plus queued responses never exceed the
   // queue depth, so the queue cannot overflow.
   assign req_ready = (state_q == ST_RUN) && (out_cnt_q < CNT_W'(CAP));
   assign accept    = req_valid && req_ready;
   assign rd_acc    = accept && !req_we;

   // Low address bits pick the bank so consecutive words alternate banks.
   assign bank_sel  = BANK_IW'(req_addr & ADDR_W'(BANKS - 1));
   assign row_sel   = ROW_W'(req_addr >> BANK_W);

   always_comb begin
      bank_ce    = '0;
      bank_we    = req_we;
      bank_mask  = req_biten;
      bank_row   = row_sel;
      bank_wdata = req_wdata;
      if (state_q == ST_INIT) begin
         bank_ce    = '1;
         bank_we    = 1'b1;
         bank_mask  = '1;
         bank_row   = init_row_q;
         bank_wdata = INIT_VALUE;
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            bank_ce[b] = accept && (bank_sel == BANK_IW'(b));
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      generic_spram_bank #(
         .DATA_W      (DATA_W),
         .PART_W      (PART_W),
         .ROWS        (ROWS),
         .ROW_W       (ROW_W),
         .RAM_LATENCY (RAM_LATENCY)
      ) u_bank (
         .clk_i   (clk),
         .ce_i    (bank_ce[b]),
         .we_i    (bank_we),
         .mask_i  (bank_mask),
         .row_i   (bank_row),
         .wdata_i (bank_wdata),
         .rdata_o (bank_rdata[b])
      );
   end

   // Read data mux, selected by the bank id that travelled with the read.
   assign arr_valid = pipe_q[RAM_LATENCY-1].valid;
   always_comb begin
      arr_data = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (pipe_q[RAM_LATENCY-1].bank == MAX_BANK_W'(b)) begin
            arr_data = bank_rdata[b];
         end
      end
   end

   // An arriving read bypasses an empty queue; it is stored only if it
   // cannot be handed over in the same cycle.
   assign q_empty    = (q_occ_q == '0);
   assign resp_valid = !q_empty || arr_valid;
   assign resp_raw   = q_empty ? arr_data : q_mem_q[q_head_q];
   assign resp_rdata = resp_valid ? resp_raw : '0;
   assign pop        = resp_valid && resp_ready;
   assign push       = arr_valid && !(q_empty && resp_ready);

   assign init_done  = init_done_q;
   assign dbg_state  = state_q;

   function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p);
      return (p == QPTR_W'(CAP - 1)) ? '0 : p + 1'b1;
   endfunction

   // FSM: clear every row after reset, then serve requests until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
         init_row_q  <= '0;
         init_done_q <= !INIT_ON_RESET;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (init_row_q == ROW_W'(ROWS - 1)) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  init_row_q <= init_row_q + 1'b1;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < RAM_LATENCY; s++) begin
            pipe_q[s] <= '0;
         end
         out_cnt_q <= '0;
         q_head_q  <= '0;
         q_tail_q  <= '0;
         q_occ_q   <= '0;
      end else begin
         pipe_q[0] <= '{valid: rd_acc, bank: MAX_BANK_W'(bank_sel)};
         for (int s = 1; s < RAM_LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
         end
         out_cnt_q <= out_cnt_q + CNT_W'(rd_acc) - CNT_W'(pop);
         if (push) begin
            q_tail_q <= ptr_inc(q_tail_q);
         end
         if (pop && !q_empty) begin
            q_head_q <= ptr_inc(q_head_q);
         end
         q_occ_q <= q_occ_q + CNT_W'(push) - CNT_W'(pop && !q_empty);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_mem_q[q_tail_q] <= arr_data;
      end
   end

endmodule

// File: tb/tb_generic_spram_ctrl.sv
module tb_generic_spram_ctrl;
   import generic_spram_pkg::*;

   localparam int LAT  = 2;
   localparam int CAP  = LAT + 1;
   localparam int ROWS = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [7:0]  req_biten = '0;
   logic [8:0]  req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [63:0] resp_rdata;
   logic        init_done;
   logic        dbg_state;

   generic_spram_ctrl #(
      .DATA_W(64), .PART_W(8), .DEPTH(512), .BANKS(2),
      .RAM_LATENCY(LAT), .INIT_ON_RESET(1'b1), .INIT_VALUE('0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_biten(req_biten), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .init_done(init_done), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_q[$];
   int          rcyc_q[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && resp_valid && resp_ready) begin
         rcyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got %h want no response (cycle %0d)", resp_rdata, cyc);
         end else begin
            check("resp_data", resp_rdata, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   // acc_cyc is the cycle in which valid && ready were both high.
   task automatic do_req(input logic we, input logic [7:0] biten, input logic [8:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp, input int tmo,
                         output bit ok, output int acc_cyc);
      ok = 1'b0;
      acc_cyc = -1;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_biten = biten;
      req_addr  = addr;
      req_wdata = wdata;
      for (int t = 0; t < tmo; t++) begin
         if (req_ready) begin
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            ok = 1'b1;
            if (!we) exp_q.push_back(exp);
            break;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic drain(input int tmo);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < tmo) begin
         @(negedge clk);
         t++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic wait_init(output int n, output bit bad);
      n = 0;
      bad = 1'b0;
      while (n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (init_done) break;
         if (req_ready) bad = 1'b1;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        we;
      logic [7:0]  biten;
      logic [8:0]  addr;
      logic [63:0] wdata;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[$];
   logic [63:0] av[4];

   initial begin
      int  n, ac, ac0, nacc;
      bit  ok, bad;

      av[0] = 64'h1111_2222_3333_4444;
      av[1] = 64'h5555_6666_7777_8888;
      av[2] = 64'h9999_AAAA_BBBB_CCCC;
      av[3] = 64'hDDDD_EEEE_FFFF_0001;

      vecs.push_back('{1'b1, 8'hFF, 9'h005, 64'hDEAD_BEEF_0123_4567, 64'h0});
      vecs.push_back('{1'b0, 8'h00, 9'h005, 64'h0, 64'hDEAD_BEEF_0123_4567});
      vecs.push_back('{1'b1, 8'hFF, 9'h009, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
      vecs.push_back('{1'b1, 8'h05, 9'h009, 64'h0, 64'h0});
      vecs.push_back('{1'b0, 8'h00, 9'h009, 64'h0, 64'hFFFF_FFFF_FF00_FF00});
      vecs.push_back('{1'b0, 8'hFF, 9'h1FF, 64'h0, 64'h0});
      vecs.push_back('{1'b1, 8'h00, 9'h006, 64'h1234, 64'h0});
      vecs.push_back('{1'b0, 8'h00, 9'h006, 64'h0, 64'h0});
      vecs.push_back('{1'b1, 8'h80, 9'h007, 64'hABCD_0000_0000_0000, 64'h0});
      vecs.push_back('{1'b0, 8'h00, 9'h007, 64'h0, 64'hAB00_0000_0000_0000});
      for (int i = 0; i < 4; i++) begin
         vecs.push_back('{1'b1, 8'hFF, 9'(i), av[i], 64'h0});
      end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_init_done", 64'(init_done), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_rdata", resp_rdata, 64'd0);

      // init timing
      @(negedge clk);
      rst_n = 1'b1;
      wait_init(n, bad);
      check("init_cycles", 64'(n), 64'(ROWS));
      check("ready_during_init", 64'(bad), 64'd0);
      check("ready_after_init", 64'(req_ready), 64'd1);

      // table-driven vectors, back to back
      foreach (vecs[i]) begin
         do_req(vecs[i].we, vecs[i].biten, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 20, ok, ac);
         check("vec_accept", 64'(ok), 64'd1);
      end
      drain(50);

      // single read latency
      rcyc_q.delete();
      do_req(1'b0, 8'h00, 9'h005, 64'h0, 64'hDEAD_BEEF_0123_4567, 20, ok, ac);
      drain(50);
      check("lat_count", 64'(rcyc_q.size()), 64'd1);
      if (rcyc_q.size() >= 1) check("lat_cycles", 64'(rcyc_q[0] - ac), 64'(LAT));

      // bank interleave: one response per cycle
      rcyc_q.delete();
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, 8'h00, 9'(i), 64'h0, av[i], 20, ok, ac);
         if (i == 0) ac0 = ac;
         check("il_accept_cycle", 64'(ac - ac0), 64'(i));
      end
      drain(50);
      check("il_count", 64'(rcyc_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < rcyc_q.size(); i++) begin
         check("il_resp_cycle", 64'(rcyc_q[i] - ac0), 64'(LAT + i));
      end

      // backpressure
      resp_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, 8'h00, 9'(i), 64'h0, av[i], 8, ok, ac);
         if (ok) nacc++;
      end
      check("bp_accepted", 64'(nacc), 64'(CAP));
      check("bp_ready_low", 64'(req_ready), 64'd0);
      check("bp_head_valid", 64'(resp_valid), 64'd1);
      check("bp_head_data", resp_rdata, av[0]);
      resp_ready = 1'b1;
      drain(50);
      for (int i = nacc; i < 4; i++) begin
         do_req(1'b0, 8'h00, 9'(i), 64'h0, av[i], 20, ok, ac);
         check("bp_late_accept", 64'(ok), 64'd1);
      end
      drain(50);

      // reset with a read outstanding
      resp_ready = 1'b0;
      do_req(1'b0, 8'h00, 9'h001, 64'h0, av[1], 20, ok, ac);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_mid_resp_rdata", resp_rdata, 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // reset at init row 100
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_init_row100_done", 64'(init_done), 64'd0);
      check("rst_init_row100_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_init(n, bad);
      check("reinit_cycles", 64'(n), 64'(ROWS));
      check("reinit_ready", 64'(bad), 64'd0);

      // no stale response after reset
      resp_ready = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (resp_valid) bad = 1'b1;
      end
      check("no_stale_resp", 64'(bad), 64'd0);

      // array was cleared again
      do_req(1'b0, 8'h00, 9'h1FF, 64'h0, 64'h0, 20, ok, ac);
      do_req(1'b0, 8'h00, 9'h005, 64'h0, 64'h0, 20, ok, ac);
      drain(50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
